axis_fifo_packetizer: RTL and testbench

- Parametrised successor to the fixed-length FIFO-to-AXI-Stream converter. Pulls words from a standard-mode FIFO with 1-cycle read latency and emits AXI-Stream packets to the DMA S2MM port.
- Packet length is runtime-programmable; output backpressure is fully honoured.
- Marks start-of-frame on tuser and end-of-packet on tlast.
- Reports busy status and a completed-packet count.

---
 rtl/axis_fifo_packetizer.sv | 182 ++++++++++++++++++
 tb/tb_axis_fifo_packetizer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_packetizer
// Description : Pulls words from a standard-mode FIFO (1-cycle read latency)
//               and emits AXI-Stream packets of runtime-programmable length.
//               A 2-entry skid buffer absorbs the read latency so output
//               backpressure is fully honoured without losing words.
//               tuser marks the first beat, tlast the final beat.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_enable          - start a new packet whenever possible
//               i_pkt_len         - beats per packet, sampled at packet start
//               i_fifo_dout       - FIFO data, valid 1 cycle after rd_en
//               i_fifo_empty      - FIFO empty flag
//               o_fifo_rd_en      - FIFO read strobe
//               m_axis_*          - AXI-Stream master (tdata/tkeep/tvalid/
//                                   tready/tlast/tuser)
//               o_busy            - high when not idle
//               o_pkt_count       - completed packets, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [LEN_WIDTH-1:0]  i_pkt_len,
    input  logic [DATA_WIDTH-1:0] i_fifo_dout,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_pkt_count
);

    localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_req;
    logic [LEN_WIDTH-1:0]  r_sent;
    logic [1:0]            r_occ;
    logic                  r_infl;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_room;
    logic                  w_rd_en;
    logic                  w_start;
    logic                  w_last_beat;

    assign w_valid     = (r_occ != 2'd0);
    assign w_pop       = w_valid & m_axis_tready;
    // Entries held plus the word still coming back from the FIFO; a new read
    // is only safe if it cannot overflow the 2-entry buffer next cycle.
    assign w_level     = {1'b0, r_occ} + {2'b00, r_infl};
    assign w_room      = (w_level < (3'd2 + {2'b00, w_pop}));
    assign w_rd_en     = (r_state == S_STREAM) & ~i_fifo_empty & (r_req < r_len) & w_room;
    assign w_start     = (r_state == S_IDLE) & i_enable & ~i_fifo_empty & (i_pkt_len != '0);
    assign w_last_beat = (r_sent == (r_len - c_len_one));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if ((r_req == r_len) && !r_infl) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The final beat may already have gone out while streaming.
                if ((r_sent == r_len) || (w_pop && w_last_beat)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_req       <= '0;
            r_sent      <= '0;
            r_occ       <= 2'd0;
            r_infl      <= 1'b0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_infl  <= w_rd_en;

            if (w_start) begin
                r_len  <= i_pkt_len;
                r_req  <= '0;
                r_sent <= '0;
            end else begin
                if (w_rd_en) begin
                    r_req <= r_req + c_len_one;
                end
                if (w_pop) begin
                    r_sent <= r_sent + c_len_one;
                end
            end

            if (r_state == S_DONE) begin
                r_pkt_count <= r_pkt_count + c_cnt_one;
            end

            // Skid buffer: buf0 is the head; the returning word lands behind
            // whatever survives this cycle's pop.
            case ({r_infl, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= i_fifo_dout;
                    end else begin
                        r_buf1 <= i_fifo_dout;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= i_fifo_dout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= i_fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_fifo_rd_en  = w_rd_en;
    assign m_axis_tdata  = r_buf0;
    assign m_axis_tkeep  = '1;
    assign m_axis_tvalid = w_valid;
    assign m_axis_tuser  = w_valid & (r_sent == '0);
    assign m_axis_tlast  = w_valid & w_last_beat;
    assign o_busy        = (r_state != S_IDLE);
    assign o_pkt_count   = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_fifo_packetizer
// Description : Self-checking bench for axis_fifo_packetizer. A FIFO model
//               with 1-cycle read latency feeds the DUT; a scoreboard queue
//               holds every word read, and each output beat is compared with
//               it along with tuser/tlast derived from the beat index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_fifo_packetizer;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int LW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_enable = 1'b0;
    logic [LW-1:0] i_pkt_len = '0;
    logic [DW-1:0] i_fifo_dout = '0;
    logic          i_fifo_empty;
    logic          o_fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          o_busy;
    logic [CW-1:0] o_pkt_count;

    always #5 clk = ~clk;

    axis_fifo_packetizer #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (i_enable),
        .i_pkt_len     (i_pkt_len),
        .i_fifo_dout   (i_fifo_dout),
        .i_fifo_empty  (i_fifo_empty),
        .o_fifo_rd_en  (o_fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .o_busy        (o_busy),
        .o_pkt_count   (o_pkt_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endfunction

    // ---------------- FIFO model (standard mode, 1-cycle latency) ----------
    logic [DW-1:0] fifo_mem [0:4095];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          flush_req = 1'b0;
    logic          samp_rd = 1'b0;
    int            next_word = 0;

    assign i_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (samp_rd && (wr_ptr != rd_ptr)) begin
            i_fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end else if (flush_req) begin
            rd_ptr <= wr_ptr;
        end
    end

    task automatic push(input logic [DW-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            push(32'hA500_0000 + 32'(next_word));
            next_word++;
        end
    endtask

    // ---------------- tready driver ----------------------------------------
    int ready_mode = 0;   // 0 always, 1 toggle, 2 random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard / reference model -------------------------
    logic [DW-1:0] exp_q [$];
    int            cur_len = 1;
    int            mdl_beat = 0;
    int            beats = 0;
    int            reads = 0;
    logic          busy_seen = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          prev_user = 1'b0;

    always @(negedge clk) begin
        samp_rd = o_fifo_rd_en;
        if (rst) begin
            // Everything buffered or in flight is lost on reset.
            exp_q.delete();
            mdl_beat   = 0;
            prev_stall = 1'b0;
        end else begin
            if (o_busy) busy_seen = 1'b1;
            if (prev_stall) begin
                chk("hold_tvalid", m_axis_tvalid, 1'b1);
                chk("hold_tdata", m_axis_tdata, prev_data);
                chk("hold_tlast", m_axis_tlast, prev_last);
                chk("hold_tuser", m_axis_tuser, prev_user);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got beat 0x%0h, required no beat", m_axis_tdata);
                end else begin
                    chk("beat_tdata", m_axis_tdata, exp_q.pop_front());
                end
                chk("beat_tuser", m_axis_tuser, mdl_beat == 0);
                chk("beat_tlast", m_axis_tlast, mdl_beat == cur_len - 1);
                chk("beat_tkeep", m_axis_tkeep, 4'hF);
                mdl_beat = (mdl_beat == cur_len - 1) ? 0 : mdl_beat + 1;
                beats++;
            end
            if (o_fifo_rd_en) begin
                chk("rd_when_empty", i_fifo_empty, 1'b0);
                exp_q.push_back(fifo_mem[rd_ptr]);
                reads++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_user  = m_axis_tuser;
        end
    end

    // ---------------- helpers -----------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int n);
        i_pkt_len = LW'(n);
        cur_len   = n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tuser", m_axis_tuser, 1'b0);
        chk("rst_rd_en", o_fifo_rd_en, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_count", o_pkt_count, 0);
        cyc();
    endtask

    task automatic flush();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        cyc();
    endtask

    task automatic wait_done(input int exp_cnt, input int budget, input string nm);
        int k = 0;
        while (!((o_pkt_count == CW'(exp_cnt)) && !o_busy) && (k < budget)) begin
            cyc();
            k++;
        end
        if (k == budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got count %0d busy %0d, required count %0d idle",
                     nm, o_pkt_count, o_busy, exp_cnt);
        end
    endtask

    task automatic wait_beats(input int target, input int budget, input string nm);
        int k = 0;
        while ((beats < target) && (k < budget)) begin
            cyc();
            k++;
        end
        if (k == budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d beats, required %0d", nm, beats, target);
        end
    endtask

    // ---------------- vector table ------------------------------------------
    typedef struct {
        int len;
        int nwords;
        int rmode;
        int exp_beats;
        int exp_pkts;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int r0;
        int pk_base;

        vecs[0] = '{len: 4,  nwords: 4,  rmode: 0, exp_beats: 4,  exp_pkts: 1};
        vecs[1] = '{len: 8,  nwords: 8,  rmode: 1, exp_beats: 8,  exp_pkts: 1};
        vecs[2] = '{len: 1,  nwords: 3,  rmode: 0, exp_beats: 3,  exp_pkts: 3};
        vecs[3] = '{len: 5,  nwords: 10, rmode: 2, exp_beats: 10, exp_pkts: 2};
        vecs[4] = '{len: 0,  nwords: 4,  rmode: 0, exp_beats: 0,  exp_pkts: 0};
        vecs[5] = '{len: 16, nwords: 48, rmode: 2, exp_beats: 48, exp_pkts: 3};

        cyc();
        do_reset();

        // Latency and first packet: 0x10..0x13 on consecutive cycles.
        ready_mode = 0;
        set_len(4);
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
        cyc();
        i_enable = 1'b1;
        @(negedge clk);
        chk("lat_c0_busy", o_busy, 1'b0);
        chk("lat_c0_rd", o_fifo_rd_en, 1'b0);
        @(negedge clk);
        chk("lat_c1_busy", o_busy, 1'b1);
        chk("lat_c1_rd", o_fifo_rd_en, 1'b1);
        @(negedge clk);
        chk("lat_c2_tvalid", m_axis_tvalid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_tvalid", m_axis_tvalid, 1'b1);
            chk("seq_tdata", m_axis_tdata, 32'h10 + 32'(k));
        end
        @(negedge clk);
        chk("seq_after_tvalid", m_axis_tvalid, 1'b0);
        cyc();
        wait_done(1, 50, "first");
        i_enable = 1'b0;
        chk("first_count", o_pkt_count, 1);

        // Table-driven packet cases.
        for (int v = 0; v < 6; v++) begin
            i_enable = 1'b0;
            do_reset();
            ready_mode = vecs[v].rmode;
            set_len(vecs[v].len);
            b0 = beats;
            r0 = reads;
            busy_seen = 1'b0;
            push_n(vecs[v].nwords);
            i_enable = 1'b1;
            if (vecs[v].exp_pkts > 0) wait_done(vecs[v].exp_pkts, 600, "vec");
            repeat (10) cyc();
            i_enable = 1'b0;
            chk("vec_beats", beats - b0, vecs[v].exp_beats);
            chk("vec_reads", reads - r0, vecs[v].exp_beats);
            chk("vec_count", o_pkt_count, vecs[v].exp_pkts);
            chk("vec_busy_seen", busy_seen, vecs[v].exp_pkts != 0);
            chk("vec_busy_end", o_busy, 1'b0);
            flush();
        end

        // FIFO underrun mid-packet.
        do_reset();
        ready_mode = 0;
        set_len(6);
        b0 = beats;
        push_n(3);
        i_enable = 1'b1;
        repeat (10) cyc();
        chk("gap_tvalid", m_axis_tvalid, 1'b0);
        chk("gap_busy", o_busy, 1'b1);
        chk("gap_beats", beats - b0, 3);
        push_n(3);
        wait_done(1, 100, "underrun");
        i_enable = 1'b0;
        chk("underrun_beats", beats - b0, 6);

        // Enable dropped after beat 2 of a len-5 packet.
        do_reset();
        set_len(5);
        b0 = beats;
        push_n(10);
        i_enable = 1'b1;
        wait_beats(b0 + 2, 50, "endrop");
        i_enable = 1'b0;
        repeat (40) cyc();
        chk("endrop_beats", beats - b0, 5);
        chk("endrop_count", o_pkt_count, 1);
        chk("endrop_busy", o_busy, 1'b0);
        flush();

        // Reset at beat 3 of a len-16 packet.
        do_reset();
        set_len(16);
        b0 = beats;
        push_n(40);
        i_enable = 1'b1;
        wait_beats(b0 + 3, 50, "midrst");
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_tlast", m_axis_tlast, 1'b0);
        chk("midrst_tuser", m_axis_tuser, 1'b0);
        chk("midrst_rd_en", o_fifo_rd_en, 1'b0);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_count", o_pkt_count, 0);
        cyc();
        wait_done(1, 100, "midrst");
        i_enable = 1'b0;
        repeat (5) cyc();
        chk("midrst_after_busy", o_busy, 1'b0);
        flush();

        // Randomized segments: random length, trickled words, random tready.
        do_reset();
        ready_mode = 2;
        pk_base = 0;
        b0 = beats;
        r0 = reads;
        for (int s = 0; s < 8; s++) begin
            int len;
            int npk;
            len = $urandom_range(1, 9);
            npk = $urandom_range(1, 3);
            set_len(len);
            i_enable = 1'b1;
            for (int w = 0; w < len * npk; w++) begin
                push_n(1);
                repeat ($urandom_range(0, 3)) cyc();
            end
            pk_base += npk;
            wait_done(pk_base, 400, "rand");
            i_enable = 1'b0;
            chk("rand_count", o_pkt_count, pk_base);
            cyc();
        end
        chk("rand_reads_eq_beats", reads - r0, beats - b0);
        chk("rand_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
